// File: rtl/mac_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the 10GE MAC transmit port.
// One requester owns the port for a whole packet; outputs are registered.
module mac_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clkTxRxInterface,
  input  logic                   rstTxRxInterface,
  input  logic [NUM_REQ-1:0]     requestPacket,
  input  logic [NUM_REQ*64-1:0]  reqData,
  input  logic [NUM_REQ-1:0]     reqValid,
  input  logic [NUM_REQ-1:0]     reqStartOfPacket,
  input  logic [NUM_REQ-1:0]     reqEndOfPacket,
  input  logic [NUM_REQ*3-1:0]   reqPacketLengthModulus,
  output logic [NUM_REQ-1:0]     reqReady,
  output logic [NUM_REQ-1:0]     grant,
  output logic [63:0]            transmitData,
  output logic                   transmitValid,
  output logic                   transmitStartOfPacket,
  output logic                   transmitEndOfPacket,
  output logic [2:0]             transmitPacketLengthModulus,
  input  logic                   transmitFIFOFull,
  output logic                   framingError,
  output logic [CNT_WIDTH-1:0]   packetCount
);

  localparam int LW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, XFER} state_t;

  state_t state, stateNext;

  logic [LW-1:0]        lastGrant;
  logic                 firstWord;
  logic                 anyReq;
  logic [2*NUM_REQ-1:0] rotReq;
  logic [LW-1:0]        pickIdx;
  logic [NUM_REQ-1:0]   pickGrant;
  logic                 accept;
  logic [63:0]          selData;
  logic                 selSop;
  logic                 selEop;
  logic [2:0]           selMod;

  assign anyReq = |requestPacket;

  // Rotate so the requester after lastGrant lands at bit 0.
  always_comb begin
    int base;
    int off;
    int sum;
    base      = int'(lastGrant) + 1;
    rotReq    = {requestPacket, requestPacket} >> base;
    off       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotReq[i]) off = i;
    end
    sum = base + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    pickIdx   = sum[LW-1:0];
    pickGrant = {{(NUM_REQ-1){1'b0}}, 1'b1} << pickIdx;
  end

  assign reqReady = (state == XFER) ?
    (grant & {NUM_REQ{~transmitFIFOFull}}) : '0;
  assign accept = |(reqValid & reqReady);

  always_comb begin
    selData = '0;
    selSop  = 1'b0;
    selEop  = 1'b0;
    selMod  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        selData = reqData[i*64 +: 64];
        selSop  = reqStartOfPacket[i];
        selEop  = reqEndOfPacket[i];
        selMod  = reqPacketLengthModulus[i*3 +: 3];
      end
    end
  end

  always_ff @(posedge clkTxRxInterface or posedge rstTxRxInterface) begin
    if (rstTxRxInterface) state <= IDLE;
    else                  state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (anyReq)           stateNext = XFER;
      XFER: if (accept && selEop) stateNext = IDLE;
      default:                    stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkTxRxInterface or posedge rstTxRxInterface) begin
    if (rstTxRxInterface) begin
      grant                       <= '0;
      lastGrant                   <= LW'(NUM_REQ - 1);
      firstWord                   <= 1'b0;
      transmitData                <= '0;
      transmitValid               <= 1'b0;
      transmitStartOfPacket       <= 1'b0;
      transmitEndOfPacket         <= 1'b0;
      transmitPacketLengthModulus <= '0;
      framingError                <= 1'b0;
      packetCount                 <= '0;
    end else begin
      transmitValid               <= accept;
      transmitStartOfPacket       <= accept & firstWord;
      transmitEndOfPacket         <= accept & selEop;
      transmitPacketLengthModulus <= (accept & selEop) ? selMod : 3'd0;
      // Missing SOP on the first word or a stray SOP later is an error.
      framingError <= accept & (firstWord ? ~selSop : selSop);
      if (state == IDLE && anyReq) begin
        grant     <= pickGrant;
        lastGrant <= pickIdx;
        firstWord <= 1'b1;
      end
      if (accept) begin
        transmitData <= selData;
        firstWord    <= 1'b0;
        if (selEop) begin
          grant       <= '0;
          packetCount <= packetCount + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
